// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state encoding and width helpers for the matmul sequencer
package matmul_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } state_t;

    function automatic int dim_width(input int max_dim);
        return $clog2(max_dim + 1);
    endfunction

    function automatic int addr_width(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

endpackage

// File: rtl/matmul_addr_walker.sv
// rtl/matmul_addr_walker.sv - i/j/k loop counters with incremental row-major A/B operand addresses
module matmul_addr_walker
    import matmul_pkg::*;
#(
    parameter int DMW = dim_width(10),
    parameter int DKW = dim_width(10),
    parameter int DNW = dim_width(10),
    parameter int AAW = addr_width(10, 10),
    parameter int BAW = addr_width(10, 10)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           step,
    input  logic [DMW-1:0] dim_m,
    input  logic [DKW-1:0] dim_k,
    input  logic [DNW-1:0] dim_n,
    output logic           k_first,
    output logic           k_last,
    output logic           j_last,
    output logic           i_last,
    output logic [AAW-1:0] a_addr,
    output logic [BAW-1:0] b_addr
);

    logic [DMW-1:0] i_cnt;
    logic [DNW-1:0] j_cnt;
    logic [DKW-1:0] k_cnt;
    logic [AAW-1:0] row_base;

    assign k_first = (k_cnt == '0);
    assign k_last  = (k_cnt == dim_k - DKW'(1));
    assign j_last  = (j_cnt == dim_n - DNW'(1));
    assign i_last  = (i_cnt == dim_m - DMW'(1));

    // row_base tracks i*K so a_addr can return to the row start without a multiply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            row_base <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
        end else if (clear) begin
            i_cnt    <= '0;
            j_cnt    <= '0;
            k_cnt    <= '0;
            row_base <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
        end else if (step) begin
            if (!k_last) begin
                k_cnt  <= k_cnt + DKW'(1);
                a_addr <= a_addr + AAW'(1);
                b_addr <= b_addr + BAW'(dim_n);
            end else begin
                k_cnt <= '0;
                if (!j_last) begin
                    j_cnt  <= j_cnt + DNW'(1);
                    a_addr <= row_base;
                    b_addr <= BAW'(j_cnt) + BAW'(1);
                end else begin
                    j_cnt    <= '0;
                    i_cnt    <= i_cnt + DMW'(1);
                    row_base <= row_base + AAW'(dim_k);
                    a_addr   <= row_base + AAW'(dim_k);
                    b_addr   <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - matmul loop-nest sequencer: operand issue, MAC credit, in-order C retire
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter  int MAX_M   = 10,
    parameter  int MAX_K   = 10,
    parameter  int MAX_N   = 10,
    parameter  int MAX_OUT = 4,
    localparam int DMW     = dim_width(MAX_M),
    localparam int DKW     = dim_width(MAX_K),
    localparam int DNW     = dim_width(MAX_N),
    localparam int AAW     = addr_width(MAX_M, MAX_K),
    localparam int BAW     = addr_width(MAX_K, MAX_N),
    localparam int CAW     = addr_width(MAX_M, MAX_N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [DMW-1:0] dim_m,
    input  logic [DKW-1:0] dim_k,
    input  logic [DNW-1:0] dim_n,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           op_valid,
    input  logic           op_ready,
    output logic           op_first,
    output logic           op_last,
    output logic [AAW-1:0] a_addr,
    output logic [BAW-1:0] b_addr,
    input  logic           res_valid,
    output logic           c_we,
    output logic [CAW-1:0] c_addr
);

    localparam int OW = $clog2(MAX_OUT + 1);

    state_t         state;
    logic [DMW-1:0] m_r;
    logic [DKW-1:0] k_r;
    logic [DNW-1:0] n_r;
    logic [OW-1:0]  outstanding;
    logic [DMW-1:0] ri;
    logic [DNW-1:0] rj;
    logic           k_first, k_last, j_last, i_last;
    logic           issue, op_fire, out_inc, dims_bad, last_retire;

    matmul_addr_walker #(
        .DMW(DMW), .DKW(DKW), .DNW(DNW), .AAW(AAW), .BAW(BAW)
    ) u_walker (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_CHECK),
        .step   (op_fire),
        .dim_m  (m_r),
        .dim_k  (k_r),
        .dim_n  (n_r),
        .k_first(k_first),
        .k_last (k_last),
        .j_last (j_last),
        .i_last (i_last),
        .a_addr (a_addr),
        .b_addr (b_addr)
    );

    // A new dot product may only start while the MAC pipeline has a free credit
    assign issue    = (state == ST_ISSUE);
    assign op_valid = issue && !(k_first && outstanding == OW'(MAX_OUT));
    assign op_first = issue && k_first;
    assign op_last  = issue && k_last;
    assign op_fire  = op_valid && op_ready;
    assign out_inc  = op_fire && op_last;

    assign c_we = res_valid && (outstanding != '0)
                  && (state == ST_ISSUE || state == ST_DRAIN);
    assign last_retire = c_we && (ri == m_r - DMW'(1)) && (rj == n_r - DNW'(1));

    assign dims_bad = (m_r == '0) || (m_r > DMW'(MAX_M))
                   || (k_r == '0) || (k_r > DKW'(MAX_K))
                   || (n_r == '0) || (n_r > DNW'(MAX_N));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            m_r         <= '0;
            k_r         <= '0;
            n_r         <= '0;
            outstanding <= '0;
            ri          <= '0;
            rj          <= '0;
            c_addr      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    m_r   <= dim_m;
                    k_r   <= dim_k;
                    n_r   <= dim_n;
                    err   <= 1'b0;
                    busy  <= 1'b1;
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    outstanding <= '0;
                    ri          <= '0;
                    rj          <= '0;
                    c_addr      <= '0;
                    if (dims_bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: if (out_inc && j_last && i_last) state <= ST_DRAIN;
                ST_DRAIN: if (last_retire) begin
                    done  <= 1'b1;
                    state <= ST_FIN;
                end
                ST_FIN: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (out_inc && !c_we)
                outstanding <= outstanding + OW'(1);
            else if (!out_inc && c_we)
                outstanding <= outstanding - OW'(1);

            // Row-major C order means the retire address is simply a running count
            if (c_we) begin
                c_addr <= c_addr + CAW'(1);
                if (rj == n_r - DNW'(1)) begin
                    rj <= '0;
                    ri <= ri + DMW'(1);
                end else begin
                    rj <= rj + DNW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - scoreboard bench with MAC model for matmul_sequencer
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int MAX_D   = 10;
    localparam int MAX_OUT = 4;
    localparam int DW      = dim_width(MAX_D);
    localparam int AW      = addr_width(MAX_D, MAX_D);

    logic          clk, rst_n, start;
    logic [DW-1:0] dim_m, dim_k, dim_n;
    logic          busy, done, err, op_valid, op_ready, op_first, op_last;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic          res_valid, c_we;

    matmul_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .busy(busy), .done(done), .err(err),
        .op_valid(op_valid), .op_ready(op_ready),
        .op_first(op_first), .op_last(op_last),
        .a_addr(a_addr), .b_addr(b_addr),
        .res_valid(res_valid), .c_we(c_we), .c_addr(c_addr)
    );

    typedef struct {
        int a;
        int b;
        bit f;
        bit l;
    } beat_t;

    beat_t exp_beat[$];
    int    exp_c[$];
    int    mac_due[$];
    beat_t eb;
    int    checks = 0, fails = 0, cyc = 0;
    int    latency, ready_pct, model_out, start_cyc, last_cwe;
    int    sm, sk, sn, pa, pb;
    bit    stray, run_active, run_bad, busy_exp, err_exp;
    bit    prev_stall, pf, pl, real_res, fire, exp_we;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, req, cyc);
        end
    endtask

    // MAC model and monitor: drive MAC-side inputs, then sample outputs 1ns later
    initial begin
        op_ready = 0;
        res_valid = 0;
        model_out = 0;
        last_cwe = 0;
        start_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                op_ready = 0;
                res_valid = 0;
                #1;
                chk("reset_flags", int'({busy, done, err, op_valid, op_first, op_last, c_we}), 0);
                chk("reset_addrs", int'({a_addr, b_addr, c_addr}), 0);
                exp_beat.delete();
                exp_c.delete();
                mac_due.delete();
                model_out = 0;
                prev_stall = 0;
                run_active = 0;
                busy_exp = 0;
                err_exp = 0;
            end else begin
                op_ready = ($urandom_range(99) < ready_pct);
                real_res = (mac_due.size() > 0) && (mac_due[0] <= cyc);
                if (real_res) void'(mac_due.pop_front());
                res_valid = real_res || stray;
                #1;
                if (done && run_active) err_exp = run_bad;
                chk("busy", int'(busy), int'(busy_exp));
                chk("err", int'(err), int'(err_exp));

                if (start && !busy) begin
                    sm = int'(dim_m);
                    sk = int'(dim_k);
                    sn = int'(dim_n);
                    run_bad = (sm < 1 || sm > MAX_D || sk < 1 || sk > MAX_D
                               || sn < 1 || sn > MAX_D);
                    if (!run_bad)
                        for (int i = 0; i < sm; i++)
                            for (int j = 0; j < sn; j++) begin
                                for (int k = 0; k < sk; k++)
                                    exp_beat.push_back('{i * sk + k, k * sn + j, k == 0, k == sk - 1});
                                exp_c.push_back(i * sn + j);
                            end
                    start_cyc = cyc;
                    run_active = 1;
                    busy_exp = 1;
                    err_exp = 0;
                end

                if (op_valid) begin
                    chk("valid_in_run", int'(exp_beat.size() > 0), 1);
                    chk("credit_stall", int'(op_first && model_out >= MAX_OUT), 0);
                end
                if (prev_stall) begin
                    chk("hold_valid", int'(op_valid), 1);
                    chk("hold_addr", int'(a_addr) * 256 + int'(b_addr), pa * 256 + pb);
                    chk("hold_flags", int'({op_first, op_last}), int'({pf, pl}));
                end
                fire = op_valid && op_ready;
                if (fire && exp_beat.size() > 0) begin
                    eb = exp_beat.pop_front();
                    chk("a_addr", int'(a_addr), eb.a);
                    chk("b_addr", int'(b_addr), eb.b);
                    chk("op_first", int'(op_first), int'(eb.f));
                    chk("op_last", int'(op_last), int'(eb.l));
                    if (op_last) mac_due.push_back(cyc + latency);
                end
                prev_stall = op_valid && !op_ready;
                pa = int'(a_addr);
                pb = int'(b_addr);
                pf = op_first;
                pl = op_last;

                exp_we = res_valid && (model_out > 0);
                if (res_valid || c_we) chk("c_we", int'(c_we), int'(exp_we));
                if (c_we && exp_c.size() > 0) begin
                    chk("c_addr", int'(c_addr), exp_c.pop_front());
                    last_cwe = cyc;
                end
                model_out = model_out + int'(fire && op_last) - int'(exp_we);

                if (done) begin
                    chk("done_in_run", int'(run_active), 1);
                    if (run_active) begin
                        if (run_bad) chk("err_done_latency", cyc, start_cyc + 2);
                        else chk("done_latency", cyc, last_cwe + 1);
                        chk("beats_left", exp_beat.size(), 0);
                        chk("results_left", exp_c.size(), 0);
                    end
                    busy_exp = 0;
                    run_active = 0;
                end
            end
        end
    end

    task automatic wait_done();
        for (int t = 0; t < 30000; t++) begin
            @(negedge clk);
            #2;
            if (done) return;
        end
        $display("FAIL done_timeout actual=none required=done_pulse");
        $fatal(1, "done never asserted");
    endtask

    task automatic go(input int m, input int k, input int n, input int lat, input int rpct);
        @(posedge clk);
        #1;
        latency = lat;
        ready_pct = rpct;
        dim_m = DW'(m);
        dim_k = DW'(k);
        dim_n = DW'(n);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        wait_done();
    endtask

    task automatic pulse_stray();
        @(posedge clk);
        #1 stray = 1;
        @(posedge clk);
        #1 stray = 0;
    endtask

    initial begin
        rst_n = 0;
        start = 0;
        dim_m = '0;
        dim_k = '0;
        dim_n = '0;
        latency = 3;
        ready_pct = 100;
        stray = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        repeat (2) @(posedge clk);

        go(1, 1, 1, 3, 100);
        go(2, 3, 2, 2, 100);
        go(4, 4, 4, 20, 100);
        go(10, 10, 10, 4, 50);
        go(3, 0, 3, 2, 100);
        repeat (3) @(posedge clk);
        go(11, 2, 2, 2, 100);
        pulse_stray();
        go(2, 2, 2, 1, 80);

        @(posedge clk);
        #1;
        latency = 3;
        ready_pct = 100;
        dim_m = DW'(10);
        dim_k = DW'(10);
        dim_n = DW'(10);
        start = 1;
        @(posedge clk);
        #1 start = 0;
        repeat (25) @(posedge clk);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        pulse_stray();
        go(3, 2, 3, 3, 70);

        for (int r = 0; r < 6; r++)
            go($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 6),
               $urandom_range(1, 25), $urandom_range(30, 100));

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
